stopwatch_lap_core: RTL

STOPWATCH_LAP_CORE -- requirements
Module: stopwatch_lap_core

---
 rtl/stopwatch_lap_core.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_lap_core.sv
// Stopwatch core: BCD mm:ss.hh timekeeping, lap capture memory with recall,
// and seven-segment decode of the displayed digits.
module stopwatch_lap_core #(
   parameter int CLK_HZ    = 50000000,
   parameter int TICK_HZ   = 100,
   parameter int LAP_DEPTH = 4
) (
   input  logic                                               CLOCK_50,
   input  logic                                               reset,
   input  logic                                               start_stop,
   input  logic                                               lap,
   input  logic                                               clear,
   input  logic                                               recall,
   output logic [23:0]                                        disp_bcd,
   output logic [6:0]                                         hex0,
   output logic [6:0]                                         hex1,
   output logic [6:0]                                         hex2,
   output logic [6:0]                                         hex3,
   output logic [6:0]                                         hex4,
   output logic [6:0]                                         hex5,
   output logic                                               running,
   output logic                                               recall_mode,
   output logic [$clog2(LAP_DEPTH+1)-1:0]                     lap_count,
   output logic [((LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1)-1:0] lap_idx,
   output logic                                               lap_full,
   output logic                                               overflow
);

   localparam int DIV   = CLK_HZ / TICK_HZ;
   localparam int PS_W  = $clog2(DIV);
   localparam int CNT_W = $clog2(LAP_DEPTH + 1);
   localparam int IDX_W = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
   localparam int MEM_N = 1 << IDX_W;

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, RECALL} state_t;

   state_t            state_q, state_d;
   logic [PS_W-1:0]   presc_q, presc_d;
   logic [23:0]       curTime_q, curTime_d;
   logic [CNT_W-1:0]  lapCount_q, lapCount_d;
   logic [IDX_W-1:0]  lapIdx_q, lapIdx_d;
   logic              overflow_q, overflow_d;
   logic [23:0]       lapMem_q [MEM_N];

   logic              doClear, doStart, doLap, doRecall;
   logic              tick, lapWrite, full, wrap;
   logic [23:0]       timeInc;

   // Only the highest-priority pulse of a cycle is ever acted upon.
   assign doClear  = clear;
   assign doStart  = start_stop & ~clear;
   assign doLap    = lap & ~clear & ~start_stop;
   assign doRecall = recall & ~clear & ~start_stop & ~lap;

   assign tick = (state_q == RUN) && (presc_q == PS_W'(DIV - 1));
   assign full = (lapCount_q == CNT_W'(LAP_DEPTH));

   // Ripple a hundredth through the BCD digits, flagging the 59:59.99 wrap.
   always_comb begin
      timeInc = curTime_q;
      wrap    = 1'b0;
      if (curTime_q[3:0] != 4'd9) begin
         timeInc[3:0] = curTime_q[3:0] + 4'd1;
      end else begin
         timeInc[3:0] = 4'd0;
         if (curTime_q[7:4] != 4'd9) begin
            timeInc[7:4] = curTime_q[7:4] + 4'd1;
         end else begin
            timeInc[7:4] = 4'd0;
            if (curTime_q[11:8] != 4'd9) begin
               timeInc[11:8] = curTime_q[11:8] + 4'd1;
            end else begin
               timeInc[11:8] = 4'd0;
               if (curTime_q[15:12] != 4'd5) begin
                  timeInc[15:12] = curTime_q[15:12] + 4'd1;
               end else begin
                  timeInc[15:12] = 4'd0;
                  if (curTime_q[19:16] != 4'd9) begin
                     timeInc[19:16] = curTime_q[19:16] + 4'd1;
                  end else begin
                     timeInc[19:16] = 4'd0;
                     if (curTime_q[23:20] != 4'd5) begin
                        timeInc[23:20] = curTime_q[23:20] + 4'd1;
                     end else begin
                        timeInc[23:20] = 4'd0;
                        wrap           = 1'b1;
                     end
                  end
               end
            end
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      presc_d    = presc_q;
      curTime_d  = curTime_q;
      lapCount_d = lapCount_q;
      lapIdx_d   = lapIdx_q;
      overflow_d = overflow_q;
      lapWrite   = 1'b0;

      if (state_q == RUN) begin
         presc_d = tick ? '0 : presc_q + 1'b1;
         if (tick) begin
            curTime_d = timeInc;
            if (wrap) overflow_d = 1'b1;
         end
      end

      unique case (state_q)
         IDLE: begin
            if (doStart) state_d = RUN;
         end
         RUN: begin
            if (doStart) begin
               state_d = PAUSE;
            end else if (doLap && !full) begin
               lapWrite   = 1'b1;
               lapCount_d = lapCount_q + 1'b1;
            end
         end
         PAUSE: begin
            if (doClear) begin
               state_d    = IDLE;
               presc_d    = '0;
               curTime_d  = '0;
               lapCount_d = '0;
               lapIdx_d   = '0;
               overflow_d = 1'b0;
            end else if (doStart) begin
               state_d = RUN;
            end else if (doRecall && (lapCount_q != '0)) begin
               state_d  = RECALL;
               lapIdx_d = '0;
            end
         end
         RECALL: begin
            if (doClear || doStart) begin
               state_d = PAUSE;
            end else if (doRecall) begin
               if (CNT_W'(lapIdx_q) == lapCount_q - CNT_W'(1)) lapIdx_d = '0;
               else                                            lapIdx_d = lapIdx_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         presc_q    <= '0;
         curTime_q  <= '0;
         lapCount_q <= '0;
         lapIdx_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         presc_q    <= presc_d;
         curTime_q  <= curTime_d;
         lapCount_q <= lapCount_d;
         lapIdx_q   <= lapIdx_d;
         overflow_q <= overflow_d;
      end
   end

   // Lap storage needs no reset: entries at or above lapCount are never shown.
   always_ff @(posedge CLOCK_50) begin
      if (lapWrite) lapMem_q[lapCount_q[IDX_W-1:0]] <= curTime_q;
   end

   function automatic logic [6:0] segDecode(input logic [3:0] digit);
      logic [6:0] seg;
      case (digit)
         4'd0:    seg = 7'h40;
         4'd1:    seg = 7'h79;
         4'd2:    seg = 7'h24;
         4'd3:    seg = 7'h30;
         4'd4:    seg = 7'h19;
         4'd5:    seg = 7'h12;
         4'd6:    seg = 7'h02;
         4'd7:    seg = 7'h78;
         4'd8:    seg = 7'h00;
         4'd9:    seg = 7'h10;
         default: seg = 7'h7F;
      endcase
      return seg;
   endfunction

   assign disp_bcd    = (state_q == RECALL) ? lapMem_q[lapIdx_q] : curTime_q;
   assign hex0        = segDecode(disp_bcd[3:0]);
   assign hex1        = segDecode(disp_bcd[7:4]);
   assign hex2        = segDecode(disp_bcd[11:8]);
   assign hex3        = segDecode(disp_bcd[15:12]);
   assign hex4        = segDecode(disp_bcd[19:16]);
   assign hex5        = segDecode(disp_bcd[23:20]);
   assign running     = (state_q == RUN);
   assign recall_mode = (state_q == RECALL);
   assign lap_count   = lapCount_q;
   assign lap_idx     = lapIdx_q;
   assign lap_full    = full;
   assign overflow    = overflow_q;

endmodule
